dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter RD_LAT, default 1, legal 1..3, SHALL set the RAM read latency in clocks.
REQ-004 clk  in  1  SHALL be the single clock; all logic on rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  in  1  SHALL mark a request, sampled only while busy=0.
REQ-007 req_we  in  1  SHALL select the access type: 1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  SHALL carry the request address.
REQ-009 req_wdata  in  DATA_W  SHALL carry the write data.
REQ-010 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-011 ack  out  1  SHALL be a one-cycle completion pulse.
REQ-012 rdata  out  DATA_W  SHALL carry the last read result.
REQ-013 ram_we / ram_addr / ram_din  out  1 / ADDR_W / DATA_W  SHALL drive the RAM port.
REQ-014 ram_dout  in  DATA_W  SHALL be the RAM read data.
REQ-015 clr_start  in  1 and clr_done  out  1 SHALL exist only under MEM_CLEAR_EN.

Function
REQ-016 The FSM SHALL have these states: IDLE, WR, RD_WAIT, CLR (CLR only under MEM_CLEAR_EN).
- All outputs registered.
REQ-017 When req=1 in IDLE at cycle N, the block SHALL latch addr/wdata/we, and at N+1 enter WR if we=1, else RD_WAIT.
REQ-018 In WR (cycle N+1), ram_we=1, ram_addr=latched addr and ram_din=latched data SHALL be driven for exactly one cycle.
- At N+2: ack=1, state IDLE.
REQ-019 RD_WAIT SHALL last RD_LAT cycles (wait counter, 2 bits) with ram_we=0 and ram_addr held.
- ram_dout captured into rdata at the edge ending the last RD_WAIT cycle.
- ack=1 and rdata valid at N+1+RD_LAT.
REQ-020 rdata SHALL hold its value until the next read capture; writes SHALL NOT modify it.
REQ-021 req while busy=1 SHALL be ignored (not queued).
- A new req SHALL be accepted in the ack cycle, giving back-to-back throughput of one access per 1+RD_LAT (read) or 2 (write) cycles.
REQ-022 ram_we SHALL be 0 and ram_din SHALL be 0 in every state except WR and CLR.
REQ-023 Address SHALL wrap at 2^ADDR_W - 1; there SHALL be no out-of-range handling.

Reset
REQ-024 Asserting reset SHALL force immediately: state IDLE, busy=0, ack=0, rdata=0, ram_we=0, ram_addr=0, ram_din=0, clr_done=0, counters 0.
REQ-025 Reset mid-operation SHALL abort the access with no ack; an in-flight WR write pulse SHALL drop immediately.
REQ-026 After reset release, the first req SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro MEM_CLEAR_EN SHALL compile in the clear sequencer.
REQ-028 With the macro defined, clr_start=1 in IDLE SHALL enter CLR.
- CLR writes 0 to addresses 0..2^ADDR_W-1, one per cycle, ram_we=1 throughout (256 cycles at default).
- Then clr_done pulses one cycle and the FSM returns to IDLE.
REQ-029 clr_start and req high in the same IDLE cycle SHALL give clear priority; the req is dropped with no ack.
REQ-030 clr_start during busy SHALL be ignored.
REQ-031 Without the macro, the CLR state, clear counter, clr_start and clr_done SHALL be absent; behaviour is otherwise identical.

Structure
REQ-032 Package dmem_ctrl_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults, and the clear-pattern constant (16'h0000).
REQ-033 Sub-module mem_clr_seq (address counter + done pulse) SHALL be the clear sequencer, instantiated only under MEM_CLEAR_EN.

Verification
REQ-034 Write addr 8'h10 data 16'hBEEF at N -> ram_we=1, ram_addr=8'h10, ram_din=16'hBEEF at N+1 only; ack at N+2.
REQ-035 Read addr 8'h10 after the write, RD_LAT=1 -> ack and rdata=16'hBEEF at N+2; repeat with RD_LAT=3 -> ack at N+4.
REQ-036 Two reads back-to-back (second req held through ack) -> second accepted in the first ack cycle; second ack 2 cycles later; req pulsed during busy -> no ack.
REQ-037 Reset asserted during WR -> ram_we=0 and all outputs 0 immediately; no ack after release.
REQ-038 MEM_CLEAR_EN: clr_start and req together -> 256 writes of 0 at addr 0..255, clr_done pulse, no req ack; read 8'hFF afterwards returns 16'h0000.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// The CLR state exists only when MEM_CLEAR_EN is defined.
package dmem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Value written to every location by the clear sequencer
    localparam logic [15:0] CLEAR_PATTERN = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2
`ifdef MEM_CLEAR_EN
        ,
        CLR     = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/dmem_ctrl_clr_seq.sv
// Clear sequencer for dmem_ctrl: walks every RAM address once and pulses done.
// Instantiated by dmem_ctrl only when MEM_CLEAR_EN is defined.
module mem_clr_seq
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done
);

    assign last = (addr == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            done <= 1'b0;
        end else begin
            if (start) begin
                addr <= '0;
            end else if (run) begin
                addr <= addr + ADDR_W'(1);
            end
            // Fires in the cycle after the final address is written
            done <= run && last;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data-memory controller: one-cycle writes, RD_LAT-cycle reads, registered RAM port.
// Optional whole-memory clear sequencer compiled in with `define MEM_CLEAR_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
`ifdef MEM_CLEAR_EN
    input  logic              clr_start,
    output logic              clr_done,
`endif
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    state_t            state, state_n;
    logic [1:0]        wait_cnt, wait_cnt_n;
    logic              ack_n;
    logic              ram_we_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_din_n;
    logic [DATA_W-1:0] rdata_n;

`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;
    logic              clr_go;
    logic              clr_run;

    assign clr_run = (state == CLR);

    mem_clr_seq #(
        .ADDR_W(ADDR_W)
    ) u_clr_seq (
        .clk   (clk),
        .reset (reset),
        .start (clr_go),
        .run   (clr_run),
        .addr  (clr_addr),
        .last  (clr_last),
        .done  (clr_done)
    );
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        ack_n      = 1'b0;
        ram_we_n   = 1'b0;
        ram_addr_n = ram_addr;
        ram_din_n  = '0;
        rdata_n    = rdata;
`ifdef MEM_CLEAR_EN
        clr_go     = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_CLEAR_EN
                // Clear wins over a simultaneous request, which is dropped
                if (clr_start) begin
                    state_n    = CLR;
                    clr_go     = 1'b1;
                    ram_we_n   = 1'b1;
                    ram_addr_n = '0;
                    ram_din_n  = DATA_W'(CLEAR_PATTERN);
                end else
`endif
                if (req) begin
                    ram_addr_n = req_addr;
                    wait_cnt_n = 2'd0;
                    if (req_we) begin
                        state_n   = WR;
                        ram_we_n  = 1'b1;
                        ram_din_n = req_wdata;
                    end else begin
                        state_n = RD_WAIT;
                    end
                end
            end
            WR: begin
                state_n = IDLE;
                ack_n   = 1'b1;
            end
            RD_WAIT: begin
                // Address is held; data is taken on the edge closing the last wait cycle
                if (wait_cnt == LAST_WAIT) begin
                    state_n    = IDLE;
                    ack_n      = 1'b1;
                    rdata_n    = ram_dout;
                    wait_cnt_n = 2'd0;
                end else begin
                    wait_cnt_n = wait_cnt + 2'd1;
                end
            end
`ifdef MEM_CLEAR_EN
            CLR: begin
                if (clr_last) begin
                    state_n = IDLE;
                end else begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = clr_addr + ADDR_W'(1);
                    ram_din_n  = DATA_W'(CLEAR_PATTERN);
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 2'd0;
            ack      <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata    <= '0;
        end else begin
            wait_cnt <= wait_cnt_n;
            ack      <= ack_n;
            ram_we   <= ram_we_n;
            ram_addr <= ram_addr_n;
            ram_din  <= ram_din_n;
            rdata    <= rdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: RD_LAT=1 instance with scoreboard, plus an RD_LAT=3 instance.
// The clear-sequencer test is compiled only when MEM_CLEAR_EN is defined.
module tb_dmem_ctrl;

    localparam int RL1 = 1;
    localparam int RL3 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr1 = '0;
    logic [15:0] wdata1 = '0;
    logic        busy1, ack1, ram_we1;
    logic [15:0] rdata1, ram_din1, ram_dout1;
    logic [7:0]  ram_addr1;

    logic        req3 = 1'b0, we3 = 1'b0;
    logic [7:0]  addr3 = '0;
    logic [15:0] wdata3 = '0;
    logic        busy3, ack3, ram_we3;
    logic [15:0] rdata3, ram_din3, ram_dout3;
    logic [7:0]  ram_addr3;

`ifdef MEM_CLEAR_EN
    logic        clr_start1 = 1'b0, clr_done1;
    logic        clr_start3 = 1'b0, clr_done3;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RL1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .req_we(we1), .req_addr(addr1),
        .req_wdata(wdata1), .busy(busy1), .ack(ack1), .rdata(rdata1),
        .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
`ifdef MEM_CLEAR_EN
        .clr_start(clr_start1), .clr_done(clr_done1),
`endif
        .ram_dout(ram_dout1)
    );

    dmem_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RL3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_we(we3), .req_addr(addr3),
        .req_wdata(wdata3), .busy(busy3), .ack(ack3), .rdata(rdata3),
        .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3),
`ifdef MEM_CLEAR_EN
        .clr_start(clr_start3), .clr_done(clr_done3),
`endif
        .ram_dout(ram_dout3)
    );

    // RAM models: latency-1 RAM reads combinationally from the registered address,
    // latency-3 RAM adds two register stages so data is valid only in the last wait cycle.
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] d3a, d3b;

    always @(posedge clk) begin
        if (ram_we1) mem1[ram_addr1] <= ram_din1;
        if (ram_we3) mem3[ram_addr3] <= ram_din3;
        d3a <= mem3[ram_addr3];
        d3b <= d3a;
    end
    assign ram_dout1 = mem1[ram_addr1];
    assign ram_dout3 = d3b;

    typedef struct {
        logic        we;
        logic [15:0] exp_rd;
        int          t0;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ack monitor for the RD_LAT=1 instance
    always @(negedge clk) begin
        sb_t e;
        if (!reset && ack1) begin
            ack_cnt1++;
            chk("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_latency", 32'(cyc - e.t0), e.we ? 32'd2 : 32'(1 + RL1));
                chk("rdata", 32'(rdata1), 32'(e.exp_rd));
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns at the falling edge of cycle N+1.
    task automatic issue1(input logic we, input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd);
        req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        sb.push_back('{we, exp_rd, cyc});
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(negedge clk);
        chk("port_ram_we", 32'(ram_we1), 32'(we));
        chk("port_ram_addr", 32'(ram_addr1), 32'(a));
        chk("port_ram_din", 32'(ram_din1), we ? 32'(d) : 32'd0);
        chk("port_busy", 32'(busy1), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run3(input logic we, input logic [7:0] a, input logic [15:0] d, output int lat);
        int t0;
        req3 = 1'b1; we3 = we; addr3 = a; wdata3 = d;
        t0 = cyc;
        @(posedge clk); #1;
        req3 = 1'b0;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack3) begin
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre;
        int lat;
        vecs[0]  = '{1'b1, 8'h10, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1'b1, 8'hFF, 16'h1234, 16'hBEEF};
        vecs[3]  = '{1'b1, 8'h00, 16'hA5A5, 16'hBEEF};
        vecs[4]  = '{1'b0, 8'hFF, 16'h0000, 16'h1234};
        vecs[5]  = '{1'b0, 8'h00, 16'h0000, 16'hA5A5};
        vecs[6]  = '{1'b1, 8'h10, 16'h0F0F, 16'hA5A5};
        vecs[7]  = '{1'b0, 8'h10, 16'h0000, 16'h0F0F};
        vecs[8]  = '{1'b1, 8'h7F, 16'hFFFF, 16'h0F0F};
        vecs[9]  = '{1'b0, 8'h7F, 16'h0000, 16'hFFFF};
        vecs[10] = '{1'b0, 8'h10, 16'h0000, 16'h0F0F};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ack", 32'(ack1), 32'd0);
        chk("rst_rdata", 32'(rdata1), 32'd0);
        chk("rst_ram_we", 32'(ram_we1), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr1), 32'd0);
        chk("rst_ram_din", 32'(ram_din1), 32'd0);

        // Release and request in the same cycle: accepted on the first edge
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            issue1(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
            drain(10);
            chk("idle_ram_we", 32'(ram_we1), 32'd0);
            chk("idle_ram_din", 32'(ram_din1), 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back reads with req held through the ack cycle
        pre = ack_cnt1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        sb.push_back('{1'b0, 16'h0F0F, cyc});
        @(posedge clk); #1;
        addr1 = 8'hFF;
        @(negedge clk);
        chk("b2b_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ack_cycle", 32'(ack1), 32'd1);
        sb.push_back('{1'b0, 16'h1234, cyc});
        @(posedge clk); #1;
        req1 = 1'b0; addr1 = '0;
        drain(10);
        repeat (3) @(negedge clk);
        chk("b2b_ack_count", 32'(ack_cnt1 - pre), 32'd2);
        @(posedge clk); #1;

        // Request pulsed while busy is ignored
        pre = ack_cnt1;
        issue1(1'b1, 8'h40, 16'h7777, 16'h1234);
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
        @(posedge clk); #1;
        req1 = 1'b0; addr1 = '0;
        drain(10);
        repeat (4) @(negedge clk);
        chk("busy_req_ack_count", 32'(ack_cnt1 - pre), 32'd1);
        @(posedge clk); #1;

        // Reset asserted during the write pulse
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h5555;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(negedge clk);
        chk("wr_before_reset", 32'(ram_we1), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_ram_we", 32'(ram_we1), 32'd0);
        chk("arst_ram_addr", 32'(ram_addr1), 32'd0);
        chk("arst_ram_din", 32'(ram_din1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_ack", 32'(ack1), 32'd0);
        chk("arst_rdata", 32'(rdata1), 32'd0);
        pre = ack_cnt1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_ack_after_reset", 32'(ack_cnt1), 32'(pre));
        chk("idle_after_reset", 32'(busy1), 32'd0);
        @(posedge clk); #1;

        // RD_LAT=3 instance
        run3(1'b1, 8'h10, 16'hBEEF, lat);
        chk("lat3_write", 32'(lat), 32'd2);
        run3(1'b0, 8'h10, 16'h0000, lat);
        chk("lat3_read", 32'(lat), 32'(1 + RL3));
        chk("lat3_rdata", 32'(rdata3), 32'hBEEF);

`ifdef MEM_CLEAR_EN
        // Clear and request together: clear wins, request dropped
        pre = ack_cnt1;
        clr_start1 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h33; wdata1 = 16'h1111;
        @(posedge clk); #1;
        clr_start1 = 1'b0; req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("clr_we", 32'(ram_we1), 32'd1);
            chk("clr_addr", 32'(ram_addr1), 32'(i));
            chk("clr_din", 32'(ram_din1), 32'd0);
        end
        @(negedge clk);
        chk("clr_done_pulse", 32'(clr_done1), 32'd1);
        chk("clr_end_we", 32'(ram_we1), 32'd0);
        chk("clr_end_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        chk("clr_done_low", 32'(clr_done1), 32'd0);
        chk("clr_no_req_ack", 32'(ack_cnt1), 32'(pre));
        @(posedge clk); #1;
        issue1(1'b0, 8'hFF, 16'h0000, 16'h0000);
        drain(10);
        chk("clr_done3_idle", 32'(clr_done3), 32'd0);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
